// File: rtl/lt24_pkg.sv
// rtl/lt24_pkg.sv - ILI9341 command codes, panel geometry, FSM states and window helpers
package lt24_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int LCD_W = 240;
   localparam int LCD_H = 320;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD_CA,
      ST_PAR_CA,
      ST_CMD_PA,
      ST_PAR_PA,
      ST_CMD_RAMWR,
      ST_PIXEL,
      ST_DONE
   } lt24_state_e;

   function automatic logic window_ok(input logic [8:0] x0, input logic [8:0] x1,
                                      input logic [8:0] y0, input logic [8:0] y1);
      return (x1 >= x0) && (y1 >= y0) && (x1 < 9'(LCD_W)) && (y1 < 9'(LCD_H));
   endfunction

   // Only meaningful for windows that passed window_ok; 240*320 fits in 17 bits.
   function automatic logic [16:0] window_pixels(input logic [8:0] x0, input logic [8:0] x1,
                                                 input logic [8:0] y0, input logic [8:0] y1);
      logic [16:0] w;
      logic [16:0] h;
      w = 17'(x1 - x0) + 17'd1;
      h = 17'(y1 - y0) + 17'd1;
      return w * h;
   endfunction

endpackage

// File: rtl/lt24_sync_fifo.sv
// rtl/lt24_sync_fifo.sv - show-ahead synchronous FIFO for the pixel stream
module lt24_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Extra pointer bit separates full (wrapped) from empty (equal).
   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lt24_window_writer.sv
// rtl/lt24_window_writer.sv - LT24 8080 write-bus driver: window setup commands then pixel stream
module lt24_window_writer
   import lt24_pkg::*;
#(
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 2,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        win_valid,
   output logic        win_ready,
   input  logic [8:0]  win_x0,
   input  logic [8:0]  win_x1,
   input  logic [8:0]  win_y0,
   input  logic [8:0]  win_y1,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [15:0] pix_data,
   output logic        busy,
   output logic        frame_done,
   output logic        win_err,
   output logic        lcd_cs_n,
   output logic        lcd_rs,
   output logic        lcd_rd_n,
   output logic        lcd_wr_n,
   output logic [15:0] lcd_data
);

   localparam logic [7:0] LOW_LAST  = 8'(WR_LOW_CYC - 1);
   localparam logic [7:0] HIGH_LAST = 8'(WR_HIGH_CYC - 1);

   lt24_state_e state;
   lt24_state_e state_nxt;

   logic [8:0]  x0_q, x1_q, y0_q, y1_q;
   logic [16:0] pix_left;
   logic [16:0] pix_pend;
   logic [1:0]  par_idx;

   logic        eng_busy;
   logic        eng_low;
   logic [7:0]  eng_cnt;
   logic        cur_pix;
   logic        wr_last;
   logic        can_start;

   logic        wr_start;
   logic        start_rs;
   logic [15:0] start_data;
   logic        pix_pop;
   logic        win_accept;
   logic        win_bad;

   logic [8:0]  par_a;
   logic [8:0]  par_b;
   logic [7:0]  param_byte;

   logic        fifo_full;
   logic        fifo_empty;
   logic [15:0] fifo_head;

   lt24_sync_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (pix_valid),
      .push_data (pix_data),
      .pop       (pix_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign pix_ready  = !fifo_full;
   assign lcd_rd_n   = 1'b1;
   assign win_ready  = (state == ST_IDLE);
   assign frame_done = (state == ST_DONE);
   assign busy       = !(state inside {ST_IDLE, ST_DONE});

   // A new write may begin when the engine is idle or in the final high cycle of the current one.
   assign wr_last   = eng_busy && !eng_low && (eng_cnt == 8'd0);
   assign can_start = !eng_busy || wr_last;

   // Pixels still to be started: the one finishing this cycle no longer counts.
   assign pix_pend = pix_left - {16'd0, (wr_last && cur_pix)};

   assign par_a = (state == ST_PAR_CA) ? x0_q : y0_q;
   assign par_b = (state == ST_PAR_CA) ? x1_q : y1_q;

   always_comb begin
      param_byte = 8'h00;
      case (par_idx)
         2'd0:    param_byte = {7'd0, par_a[8]};
         2'd1:    param_byte = par_a[7:0];
         2'd2:    param_byte = {7'd0, par_b[8]};
         default: param_byte = par_b[7:0];
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wr_start   = 1'b0;
      start_rs   = 1'b1;
      start_data = 16'h0000;
      pix_pop    = 1'b0;
      win_accept = 1'b0;
      win_bad    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               if (window_ok(win_x0, win_x1, win_y0, win_y1)) begin
                  win_accept = 1'b1;
                  state_nxt  = ST_CMD_CA;
               end else begin
                  win_bad = 1'b1;
               end
            end
         end
         ST_CMD_CA: begin
            if (can_start) begin
               wr_start   = 1'b1;
               start_rs   = 1'b0;
               start_data = {8'h00, CMD_CASET};
               state_nxt  = ST_PAR_CA;
            end
         end
         ST_PAR_CA: begin
            if (can_start) begin
               wr_start   = 1'b1;
               start_data = {8'h00, param_byte};
               if (par_idx == 2'd3) begin
                  state_nxt = ST_CMD_PA;
               end
            end
         end
         ST_CMD_PA: begin
            if (can_start) begin
               wr_start   = 1'b1;
               start_rs   = 1'b0;
               start_data = {8'h00, CMD_PASET};
               state_nxt  = ST_PAR_PA;
            end
         end
         ST_PAR_PA: begin
            if (can_start) begin
               wr_start   = 1'b1;
               start_data = {8'h00, param_byte};
               if (par_idx == 2'd3) begin
                  state_nxt = ST_CMD_RAMWR;
               end
            end
         end
         ST_CMD_RAMWR: begin
            if (can_start) begin
               wr_start   = 1'b1;
               start_rs   = 1'b0;
               start_data = {8'h00, CMD_RAMWR};
               state_nxt  = ST_PIXEL;
            end
         end
         ST_PIXEL: begin
            if (can_start) begin
               if (pix_pend == 17'd0) begin
                  state_nxt = ST_DONE;
               end else if (!fifo_empty) begin
                  wr_start   = 1'b1;
                  start_data = fifo_head;
                  pix_pop    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         x0_q     <= '0;
         x1_q     <= '0;
         y0_q     <= '0;
         y1_q     <= '0;
         pix_left <= '0;
         par_idx  <= '0;
         eng_busy <= 1'b0;
         eng_low  <= 1'b0;
         eng_cnt  <= '0;
         cur_pix  <= 1'b0;
         win_err  <= 1'b0;
         lcd_cs_n <= 1'b1;
         lcd_rs   <= 1'b1;
         lcd_wr_n <= 1'b1;
         lcd_data <= '0;
      end else begin
         win_err  <= win_bad;
         lcd_cs_n <= !(state_nxt inside {ST_CMD_CA, ST_PAR_CA, ST_CMD_PA,
                                         ST_PAR_PA, ST_CMD_RAMWR, ST_PIXEL});

         if (wr_start && (state == ST_PAR_CA || state == ST_PAR_PA)) begin
            par_idx <= par_idx + 2'd1;
         end

         // rs/data are only reloaded at the start of a write, so they hold through both phases.
         if (wr_start) begin
            eng_busy <= 1'b1;
            eng_low  <= 1'b1;
            eng_cnt  <= LOW_LAST;
            cur_pix  <= (state == ST_PIXEL);
            lcd_wr_n <= 1'b0;
            lcd_rs   <= start_rs;
            lcd_data <= start_data;
         end else if (eng_busy) begin
            if (eng_cnt != 8'd0) begin
               eng_cnt <= eng_cnt - 8'd1;
            end else if (eng_low) begin
               eng_low  <= 1'b0;
               eng_cnt  <= HIGH_LAST;
               lcd_wr_n <= 1'b1;
            end else begin
               eng_busy <= 1'b0;
            end
         end

         if (wr_last && cur_pix) begin
            pix_left <= pix_left - 17'd1;
         end

         if (win_accept) begin
            x0_q     <= win_x0;
            x1_q     <= win_x1;
            y0_q     <= win_y0;
            y1_q     <= win_y1;
            pix_left <= window_pixels(win_x0, win_x1, win_y0, win_y1);
            par_idx  <= '0;
         end
      end
   end

endmodule
